// File: rtl/sr_latch_if.sv
// Bundles the per-lane set/reset requests and the latch state outputs of
// sr_latch. The master side drives the requests, the slave side is the latch.
interface sr_latch_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] invalid;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output en, s, r,
    input  q, qb, invalid, err_sticky, err_count
  );

  modport slave (
    input  en, s, r,
    output q, qb, invalid, err_sticky, err_count
  );
endinterface

// File: rtl/sr_latch.sv
// Clocked multi-lane SR storage cell. Each lane behaves like a classic SR
// latch, but every bit of state lives in a flop on clk, so there are no
// combinational loops and no combinational path from s/r to q/qb.
// Both requests high in one lane (forbidden) follows FORBID_MODE, raises that
// lane's invalid flag and is recorded once per edge in a saturating counter
// and a sticky error flag.
module sr_latch #(
  parameter int WIDTH       = 1,
  parameter int FORBID_MODE = 0,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  sr_latch_if.slave  bus
);

  // Out-of-range policy values fall back to the NOR-equivalent behaviour.
  localparam logic [1:0] EFF_MODE =
    ((FORBID_MODE >= 1) && (FORBID_MODE <= 3)) ? 2'(FORBID_MODE) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qb_r;
  logic [WIDTH-1:0] invalid_r;
  logic             err_sticky_r;
  logic [CNT_W-1:0] err_count_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] qb_nxt_s;
  logic [WIDTH-1:0] invalid_nxt_s;
  logic             err_sticky_nxt_s;
  logic [CNT_W-1:0] err_count_nxt_s;
  logic             forbid_s;

  // One edge counts as a single event however many lanes are forbidden.
  assign forbid_s = |(bus.s & bus.r);

  // Per-lane next state: hold / reset / set / forbidden policy.
  always_comb begin
    q_nxt_s       = q_r;
    qb_nxt_s      = qb_r;
    invalid_nxt_s = invalid_r;
    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({bus.s[i], bus.r[i]})
          2'b00: begin
            invalid_nxt_s[i] = 1'b0;
            // Leaving the NOR-style forbidden state: both outputs were low,
            // the stored value is 0, so the complement comes back high.
            if (invalid_r[i] && (EFF_MODE == 2'd0)) begin
              q_nxt_s[i]  = 1'b0;
              qb_nxt_s[i] = 1'b1;
            end else begin
              q_nxt_s[i]  = q_r[i];
              qb_nxt_s[i] = qb_r[i];
            end
          end
          2'b01: begin
            q_nxt_s[i]       = 1'b0;
            qb_nxt_s[i]      = 1'b1;
            invalid_nxt_s[i] = 1'b0;
          end
          2'b10: begin
            q_nxt_s[i]       = 1'b1;
            qb_nxt_s[i]      = 1'b0;
            invalid_nxt_s[i] = 1'b0;
          end
          2'b11: begin
            invalid_nxt_s[i] = 1'b1;
            case (EFF_MODE)
              2'd0: begin
                q_nxt_s[i]  = 1'b0;
                qb_nxt_s[i] = 1'b0;
              end
              2'd1: begin
                q_nxt_s[i]  = 1'b1;
                qb_nxt_s[i] = 1'b0;
              end
              2'd2: begin
                q_nxt_s[i]  = 1'b0;
                qb_nxt_s[i] = 1'b1;
              end
              default: begin
                q_nxt_s[i]  = q_r[i];
                qb_nxt_s[i] = qb_r[i];
              end
            endcase
          end
          default: begin
            q_nxt_s[i]       = q_r[i];
            qb_nxt_s[i]      = qb_r[i];
            invalid_nxt_s[i] = invalid_r[i];
          end
        endcase
      end
    end else begin
      q_nxt_s       = q_r;
      qb_nxt_s      = qb_r;
      invalid_nxt_s = invalid_r;
    end
  end

  // Error accounting: sticky flag plus a counter that saturates instead of wrapping.
  always_comb begin
    err_sticky_nxt_s = err_sticky_r;
    err_count_nxt_s  = err_count_r;
    if (bus.en && forbid_s) begin
      err_sticky_nxt_s = 1'b1;
      if (err_count_r == CNT_MAX) begin
        err_count_nxt_s = err_count_r;
      end else begin
        err_count_nxt_s = err_count_r + CNT_ONE;
      end
    end else begin
      err_sticky_nxt_s = err_sticky_r;
      err_count_nxt_s  = err_count_r;
    end
  end

  // State registers; reset forces the idle values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r          <= {WIDTH{1'b0}};
      qb_r         <= {WIDTH{1'b1}};
      invalid_r    <= {WIDTH{1'b0}};
      err_sticky_r <= 1'b0;
      err_count_r  <= {CNT_W{1'b0}};
    end else begin
      q_r          <= q_nxt_s;
      qb_r         <= qb_nxt_s;
      invalid_r    <= invalid_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign bus.q          = q_r;
  assign bus.qb         = qb_r;
  assign bus.invalid    = invalid_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.err_count  = err_count_r;

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch: one instance per forbidden-input policy
// (plus an out-of-range policy value) and a 4-lane instance with a 2-bit
// counter for saturation and lane independence. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_sr_latch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sr_latch_if #(.WIDTH(1), .CNT_W(8)) if0 ();
  sr_latch_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  sr_latch_if #(.WIDTH(1), .CNT_W(8)) if2 ();
  sr_latch_if #(.WIDTH(1), .CNT_W(8)) if3 ();
  sr_latch_if #(.WIDTH(1), .CNT_W(8)) if5 ();
  sr_latch_if #(.WIDTH(4), .CNT_W(2)) ifc ();

  sr_latch #(.WIDTH(1), .FORBID_MODE(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  sr_latch #(.WIDTH(1), .FORBID_MODE(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
  sr_latch #(.WIDTH(1), .FORBID_MODE(2), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(if2));
  sr_latch #(.WIDTH(1), .FORBID_MODE(3), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(if3));
  sr_latch #(.WIDTH(1), .FORBID_MODE(5), .CNT_W(8)) u5 (.clk(clk), .rst(rst), .bus(if5));
  sr_latch #(.WIDTH(4), .FORBID_MODE(0), .CNT_W(2)) uc (.clk(clk), .rst(rst), .bus(ifc));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Let n rising edges pass, then return on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset applied with every request high; outputs must be idle at once.
    rst = 1'b1;
    if0.en = 1'b1; if0.s = 1'b1; if0.r = 1'b1;
    if1.en = 1'b1; if1.s = 1'b1; if1.r = 1'b1;
    if2.en = 1'b1; if2.s = 1'b1; if2.r = 1'b1;
    if3.en = 1'b1; if3.s = 1'b1; if3.r = 1'b1;
    if5.en = 1'b1; if5.s = 1'b1; if5.r = 1'b1;
    ifc.en = 1'b1; ifc.s = 4'hF; ifc.r = 4'hF;
    #1;
    chk("rst_async_q",   32'(if0.q),          32'h0);
    chk("rst_async_qb",  32'(if0.qb),         32'h1);
    chk("rst_async_inv", 32'(if0.invalid),    32'h0);
    chk("rst_async_cnt", 32'(if0.err_count),  32'h0);
    chk("rst_async_qbc", 32'(ifc.qb),         32'hF);
    step(2);
    chk("rst_hold_q",    32'(if0.q),          32'h0);
    chk("rst_hold_qb",   32'(if0.qb),         32'h1);
    chk("rst_hold_inv",  32'(if0.invalid),    32'h0);
    chk("rst_hold_stk",  32'(if0.err_sticky), 32'h0);
    chk("rst_hold_cnt",  32'(if0.err_count),  32'h0);

    // Release reset; nothing changes before the first edge.
    rst = 1'b0;
    if0.s = 1'b0; if0.r = 1'b1;
    if1.s = 1'b0; if1.r = 1'b1;
    if2.s = 1'b0; if2.r = 1'b1;
    if3.s = 1'b1; if3.r = 1'b0;
    if5.s = 1'b1; if5.r = 1'b0;
    ifc.s = 4'h0; ifc.r = 4'h0;
    #1;
    chk("rel_q",   32'(if0.q),         32'h0);
    chk("rel_cnt", 32'(if0.err_count), 32'h0);
    @(negedge clk);

    // Mode 0 sequence, 10 cycles per step.
    step(10);
    chk("m0_r_q",  32'(if0.q),  32'h0);
    chk("m0_r_qb", 32'(if0.qb), 32'h1);
    if0.s = 1'b0; if0.r = 1'b0;
    step(10);
    chk("m0_hold_q",  32'(if0.q),  32'h0);
    chk("m0_hold_qb", 32'(if0.qb), 32'h1);
    if0.s = 1'b1; if0.r = 1'b0;
    step(1);
    chk("m0_set_q",  32'(if0.q),  32'h1);
    chk("m0_set_qb", 32'(if0.qb), 32'h0);
    step(9);
    if0.s = 1'b1; if0.r = 1'b1;
    step(1);
    chk("m0_forb_q",   32'(if0.q),          32'h0);
    chk("m0_forb_qb",  32'(if0.qb),         32'h0);
    chk("m0_forb_inv", 32'(if0.invalid),    32'h1);
    chk("m0_forb_stk", 32'(if0.err_sticky), 32'h1);
    chk("m0_forb_cnt", 32'(if0.err_count),  32'h1);
    step(9);
    chk("m0_forb10_cnt", 32'(if0.err_count), 32'd10);
    chk("m0_forb10_qb",  32'(if0.qb),        32'h0);
    if0.s = 1'b0; if0.r = 1'b0;
    step(1);
    chk("m0_leave_q",   32'(if0.q),          32'h0);
    chk("m0_leave_qb",  32'(if0.qb),         32'h1);
    chk("m0_leave_inv", 32'(if0.invalid),    32'h0);
    chk("m0_leave_stk", 32'(if0.err_sticky), 32'h1);
    chk("m0_leave_cnt", 32'(if0.err_count),  32'd10);

    // Policies 1/2 from q=0, policy 3 and out-of-range from q=1.
    chk("m3_pre_q", 32'(if3.q), 32'h1);
    if1.s = 1'b1; if1.r = 1'b1;
    if2.s = 1'b1; if2.r = 1'b1;
    if3.s = 1'b1; if3.r = 1'b1;
    if5.s = 1'b1; if5.r = 1'b1;
    step(1);
    chk("m1_q",   32'(if1.q),         32'h1);
    chk("m1_qb",  32'(if1.qb),        32'h0);
    chk("m1_inv", 32'(if1.invalid),   32'h1);
    chk("m1_cnt", 32'(if1.err_count), 32'h1);
    chk("m2_q",   32'(if2.q),         32'h0);
    chk("m2_qb",  32'(if2.qb),        32'h1);
    chk("m2_inv", 32'(if2.invalid),   32'h1);
    chk("m2_cnt", 32'(if2.err_count), 32'h1);
    chk("m3_q",   32'(if3.q),         32'h1);
    chk("m3_qb",  32'(if3.qb),        32'h0);
    chk("m3_inv", 32'(if3.invalid),   32'h1);
    chk("m3_cnt", 32'(if3.err_count), 32'h1);
    chk("m5_q",   32'(if5.q),         32'h0);
    chk("m5_qb",  32'(if5.qb),        32'h0);
    chk("m5_inv", 32'(if5.invalid),   32'h1);
    if1.s = 1'b0; if1.r = 1'b0;
    if2.s = 1'b0; if2.r = 1'b0;
    if3.s = 1'b0; if3.r = 1'b0;
    if5.s = 1'b0; if5.r = 1'b0;
    step(1);
    chk("m1_hold_q",   32'(if1.q),       32'h1);
    chk("m2_hold_qb",  32'(if2.qb),      32'h1);
    chk("m3_hold_q",   32'(if3.q),       32'h1);
    chk("m3_hold_inv", 32'(if3.invalid), 32'h0);
    chk("m5_hold_qb",  32'(if5.qb),      32'h1);

    // Enable gating on the mode 0 instance.
    if0.s = 1'b1; if0.r = 1'b0;
    step(1);
    chk("en_pre_q", 32'(if0.q), 32'h1);
    if0.en = 1'b0; if0.s = 1'b0; if0.r = 1'b1;
    step(5);
    chk("en_off_r_q", 32'(if0.q), 32'h1);
    if0.s = 1'b1; if0.r = 1'b1;
    step(5);
    chk("en_off_f_q",   32'(if0.q),         32'h1);
    chk("en_off_f_qb",  32'(if0.qb),        32'h0);
    chk("en_off_f_inv", 32'(if0.invalid),   32'h0);
    chk("en_off_f_cnt", 32'(if0.err_count), 32'd10);
    if0.en = 1'b1; if0.s = 1'b0; if0.r = 1'b1;
    step(1);
    chk("en_on_q",   32'(if0.q),         32'h0);
    chk("en_on_qb",  32'(if0.qb),        32'h1);
    chk("en_on_cnt", 32'(if0.err_count), 32'd10);

    // Saturation on the 2-bit counter, all four lanes forbidden together.
    chk("c_pre_cnt", 32'(ifc.err_count), 32'h0);
    ifc.s = 4'hF; ifc.r = 4'hF;
    step(1);
    chk("c_cnt1", 32'(ifc.err_count),  32'd1);
    chk("c_stk",  32'(ifc.err_sticky), 32'h1);
    chk("c_inv",  32'(ifc.invalid),    32'hF);
    chk("c_qb",   32'(ifc.qb),         32'h0);
    step(1);
    chk("c_cnt2", 32'(ifc.err_count), 32'd2);
    step(1);
    chk("c_cnt3", 32'(ifc.err_count), 32'd3);
    step(1);
    chk("c_cnt4", 32'(ifc.err_count), 32'd3);
    step(1);
    chk("c_cnt5", 32'(ifc.err_count), 32'd3);
    step(1);
    chk("c_cnt6", 32'(ifc.err_count), 32'd3);
    chk("c_stk6", 32'(ifc.err_sticky), 32'h1);

    // Reset mid-hold takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk("c_rst_q",   32'(ifc.q),          32'h0);
    chk("c_rst_qb",  32'(ifc.qb),         32'hF);
    chk("c_rst_inv", 32'(ifc.invalid),    32'h0);
    chk("c_rst_stk", 32'(ifc.err_sticky), 32'h0);
    chk("c_rst_cnt", 32'(ifc.err_count),  32'h0);
    chk("u0_rst_stk", 32'(if0.err_sticky), 32'h0);
    step(1);
    chk("c_rsth_cnt", 32'(ifc.err_count), 32'h0);

    // Lanes are independent; one forbidden lane counts as one event.
    rst = 1'b0;
    ifc.s = 4'b0110; ifc.r = 4'b0011;
    step(1);
    chk("lane_q",   32'(ifc.q),         32'h4);
    chk("lane_qb",  32'(ifc.qb),        32'h9);
    chk("lane_inv", 32'(ifc.invalid),   32'h2);
    chk("lane_cnt", 32'(ifc.err_count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
# sr_latch

Clocked set/reset storage element with complementary outputs, `WIDTH` independent bit lanes and forbidden-input detection. It replaces free-running cross-coupled NOR latches wherever set/clear flags are held. All state is registered on one clock, so the block is safe for synthesis and static timing. Each lane behaves as a classic SR cell. Both inputs high (the forbidden combination) is handled by a configurable policy and is counted for debug.

## Interface
- `WIDTH`, 1: number of independent SR lanes.
- `FORBID_MODE`, 0: S=R=1 policy. 0 = NOR-equivalent, 1 = set-dominant, 2 = reset-dominant, 3 = hold.
- `CNT_W`, 8: width of the forbidden-event counter.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: update enable. When 0, all state holds.
- `s` input WIDTH: per-lane set request.
- `r` input WIDTH: per-lane reset request.
- `q` output WIDTH: per-lane state.
- `qb` output WIDTH: per-lane complement output. Not strictly `~q` in mode 0; see Operation.
- `invalid` output WIDTH: per-lane flag, high while that lane is in the forbidden state.
- `err_sticky` output 1: set on any forbidden event, cleared only by `rst`.
- `err_count` output CNT_W: number of forbidden events, saturating.

## Operation
Per lane, evaluated on each clock edge while `en`=1:
- s=0, r=0: hold. `q` and `qb` are unchanged, except that a lane leaving forbidden in mode 0 goes to q=0, qb=1.
- s=0, r=1: q=0, qb=1, invalid=0.
- s=1, r=0: q=1, qb=0, invalid=0.
- s=1, r=1, handled according to `FORBID_MODE`:
  - Mode 0: q=0, qb=0, invalid=1. The stored state is cleared to 0, so a following hold yields q=0, qb=1.
  - Mode 1: q=1, qb=0, invalid=1.
  - Mode 2: q=0, qb=1, invalid=1.
  - Mode 3: q and qb unchanged, invalid=1.
- `invalid` clears on the first enabled edge where the lane is not s=r=1.

Error accounting:
- A forbidden event is an enabled edge where at least one lane has s=r=1.
- Each event increments `err_count` by exactly 1, regardless of how many lanes are forbidden.
- `err_count` saturates at 2^CNT_W-1 and does not wrap.
- `err_sticky` is set on the first event and stays high until `rst`.

Enable and parameters:
- `en`=0 freezes `q`, `qb`, `invalid` and the counters. s and r are ignored.
- A `FORBID_MODE` value outside 0..3 behaves as mode 0.

## Timing
- Reset values, applied immediately on `rst` assertion without waiting for a clock: q=0, qb=all ones, invalid=0, err_sticky=0, err_count=0.
- Reset dominates every input. Asserting reset mid-operation aborts any state and holds the reset values while high.
- The first update happens on the first rising edge after `rst` deasserts.
- Latency: inputs sampled at edge N appear on all outputs after edge N. No combinational path from s/r to q/qb.
- Simultaneous events: s=r=1 on all lanes in one cycle counts once. At counter saturation the event still sets `err_sticky`.
- Inputs are synchronous to `clk`. The design has no metastability protection.

## Test plan
- Reset: assert `rst` with s=r=1 -> q=0, qb=1, invalid=0, err_count=0 during reset and on release.
- Sequence with WIDTH=1, mode 0, 10 cycles per step:
  - (s,r)=(0,1) -> q=0, qb=1.
  - (0,0) -> q=0, qb=1 held.
  - (1,0) -> q=1, qb=0.
  - (1,1) -> q=0, qb=0, invalid=1, err_sticky=1, err_count=1 after one edge.
  - (0,0) -> q=0, qb=1, invalid=0.
- Modes 1, 2 and 3: from q=1 (mode 3) or from q=0 (modes 1 and 2), apply (1,1):
  - Mode 1 -> q=1, qb=0.
  - Mode 2 -> q=0, qb=1.
  - Mode 3 -> q=1, qb=0 held.
  - All modes -> invalid=1, err_count=1.
- Enable: set q=1, drop en, apply (0,1) and (1,1) for 5 cycles -> q=1 held, err_count unchanged. Raise en with (0,1) -> q=0 after one edge.
- Counter: CNT_W=2, WIDTH=4, hold s=r=4'b1111 for 6 cycles -> err_count steps 1, 2, 3, 3, 3, 3 and err_sticky=1. Assert `rst` mid-hold -> all outputs return to reset values immediately.
